// File: rtl/mem_access_unit.sv
// Load/store unit: aligns core byte/half/word/double accesses onto an XLEN-wide memory bus.
// Latency: handshake at N, first beat at N+1, response two cycles after the handshake for a zero-wait beat.
// Backpressure: req_ready only in IDLE; each beat holds mem_* stable until mem_ready or TIMEOUT expiry.
// Optional build macro MEM_ACCESS_SPLIT_EN: boundary-crossing accesses issue two beats instead of erroring.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

  state_t              state, state_nxt;
  logic                started;
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [9:0]          wait_cnt, wait_nxt;
  logic [XLEN-1:0]     rdata_q, rdata_nxt;
  logic                err_q, err_nxt;

  logic                handshake;
  logic                req_bad_size;
  logic                req_reject;
  logic                split_beat;

  logic [OFF_W-1:0]    off_q;
  logic [ADDR_W-1:0]   base_addr;
  logic [NB-1:0]       size_mask;
  logic [XLEN-1:0]     wdata_masked;
  logic [2*NB-1:0]     lane_mask_w;
  logic [2*XLEN-1:0]   lane_data_w;
  logic [XLEN-1:0]     raw_load;
  logic                sign_bit;
  logic [XLEN-1:0]     ext_load;

  assign handshake    = req_valid & req_ready;
  assign req_bad_size = (XLEN == 32) && (req_size == 2'b11);

  assign off_q     = addr_q[OFF_W-1:0];
  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef MEM_ACCESS_SPLIT_EN
  logic [4:0]          req_nbytes;
  logic [4:0]          req_end;
  logic [4:0]          end_q;
  logic [XLEN-1:0]     beat1_q;
  logic [2*XLEN-1:0]   rd_cat;

  // Any boundary crossing can be served by two beats, so only the size can be illegal.
  always_comb begin
    req_nbytes = 5'd1 << req_size;
    req_end    = 5'(req_addr[OFF_W-1:0]) + req_nbytes;
    req_reject = req_bad_size;
  end

  assign end_q      = 5'(off_q) + (5'd1 << size_q);
  assign split_beat = (end_q > 5'(NB));

  // Hold the low-address beat's read data until the second beat completes the merge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat1_q <= '0;
    end else if (state == BEAT1 && mem_ready) begin
      beat1_q <= mem_rdata;
    end
  end

  // Concatenate both beats so one shift right-aligns the requested bytes.
  always_comb begin
    rd_cat   = (state == BEAT2) ? {mem_rdata, beat1_q} : {{XLEN{1'b0}}, mem_rdata};
    raw_load = XLEN'(rd_cat >> {off_q, 3'b000});
  end
`else
  logic [2:0] req_amask;
  logic       req_misal;

  // Without splitting, any access not naturally aligned to its size is refused.
  always_comb begin
    case (req_size)
      2'b00:   req_amask = 3'b000;
      2'b01:   req_amask = 3'b001;
      2'b10:   req_amask = 3'b011;
      default: req_amask = 3'b111;
    endcase
    req_misal  = |(req_addr[2:0] & req_amask);
    req_reject = req_bad_size | req_misal;
  end

  assign split_beat = 1'b0;
  assign raw_load   = mem_rdata >> {off_q, 3'b000};
`endif

  // Byte-lane mask of the access size, and store data trimmed to that size.
  always_comb begin
    size_mask = '0;
    case (size_q)
      2'b00:   size_mask[0]   = 1'b1;
      2'b01:   size_mask[1:0] = 2'b11;
      2'b10:   size_mask[3:0] = 4'b1111;
      default: size_mask      = '1;
    endcase
    for (int i = 0; i < NB; i++) begin
      wdata_masked[i*8 +: 8] = size_mask[i] ? wdata_q[i*8 +: 8] : 8'h00;
    end
    lane_mask_w = {{NB{1'b0}}, size_mask} << off_q;
    lane_data_w = {{XLEN{1'b0}}, wdata_masked} << {off_q, 3'b000};
  end

  // Zero/sign-extend the right-aligned load bytes to the full register width.
  always_comb begin
    case (size_q)
      2'b00:   sign_bit = raw_load[7];
      2'b01:   sign_bit = raw_load[15];
      2'b10:   sign_bit = raw_load[31];
      default: sign_bit = raw_load[XLEN-1];
    endcase
    sign_bit = sign_bit & ~uns_q;
    for (int i = 0; i < NB; i++) begin
      ext_load[i*8 +: 8] = size_mask[i] ? raw_load[i*8 +: 8] : {8{sign_bit}};
    end
  end

  // Memory bus is driven only during a beat; BEAT2 covers the upper aligned word.
  always_comb begin
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (state == BEAT1) begin
      mem_valid = 1'b1;
      mem_we    = we_q;
      mem_addr  = base_addr;
      mem_wdata = lane_data_w[XLEN-1:0];
      mem_wstrb = we_q ? lane_mask_w[NB-1:0] : '0;
    end else if (state == BEAT2) begin
      mem_valid = 1'b1;
      mem_we    = we_q;
      mem_addr  = base_addr + ADDR_W'(NB);
      mem_wdata = lane_data_w[2*XLEN-1:XLEN];
      mem_wstrb = we_q ? lane_mask_w[2*NB-1:NB] : '0;
    end
  end

  // Next-state logic with per-beat wait counting and response capture.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (handshake) begin
          wait_nxt  = '0;
          rdata_nxt = '0;
          err_nxt   = 1'b0;
          if (req_reject) begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = BEAT1;
          end
        end
      end
      BEAT1, BEAT2: begin
        if (mem_ready) begin
          wait_nxt = '0;
          if (state == BEAT1 && split_beat) begin
            state_nxt = BEAT2;
          end else begin
            state_nxt = RESP;
            rdata_nxt = we_q ? '0 : ext_load;
          end
        end else if (wait_cnt == 10'(TIMEOUT - 1)) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
          rdata_nxt = '0;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + 10'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and response registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      rdata_q  <= rdata_nxt;
      err_q    <= err_nxt;
    end
  end

  // Keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  // Request fields are captured on the handshake and held for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (handshake) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready = started && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = (state == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32, TIMEOUT=4).
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: mem_ready is driven directly per step to exercise waits and timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the unit idle; returns at the falling edge after the handshake.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    reset = 1'b1;
    #1 chk("ready_before_first_edge", req_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_first_edge", req_ready, 1);
    @(negedge clk);

    // Signed byte load at 0x103, zero-wait memory; mem_ready high while idle is ignored.
    mem_ready = 1'b1; mem_rdata = 32'h80112233;
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    chk("lb_mem_valid", mem_valid, 1);
    chk("lb_mem_addr", mem_addr, 32'h100);
    chk("lb_mem_wstrb", mem_wstrb, 0);
    chk("lb_mem_we", mem_we, 0);
    chk("lb_rsp_early", rsp_valid, 0);
    step();
    chk("lb_rsp_valid", rsp_valid, 1);
    chk("lb_rsp_rdata", rsp_rdata, 32'hFFFFFF80);
    chk("lb_rsp_err", rsp_err, 0);
    chk("lb_mem_dropped", mem_valid, 0);
    step();
    chk("lb_rsp_one_cycle", rsp_valid, 0);

    // Unsigned byte load, same lane.
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    step();
    chk("lbu_rsp_rdata", rsp_rdata, 32'h00000080);
    step();

    // Signed half load from the upper half-word.
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    step();
    chk("lh_rsp_rdata", rsp_rdata, 32'hFFFF8011);
    step();

    // Half store with one wait cycle; bus must hold steady.
    mem_ready = 1'b0;
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF);
    chk("sh_mem_addr", mem_addr, 32'h200);
    chk("sh_mem_wstrb", mem_wstrb, 4'b1100);
    chk("sh_mem_wdata", mem_wdata, 32'hBEEF0000);
    chk("sh_mem_we", mem_we, 1);
    step();
    chk("sh_hold_valid", mem_valid, 1);
    chk("sh_hold_addr", mem_addr, 32'h200);
    chk("sh_hold_wdata", mem_wdata, 32'hBEEF0000);
    chk("sh_no_rsp_yet", rsp_valid, 0);
    mem_ready = 1'b1;
    step();
    chk("sh_rsp_valid", rsp_valid, 1);
    chk("sh_rsp_err", rsp_err, 0);
    chk("sh_rsp_rdata", rsp_rdata, 0);
    step();

    // Byte store to lane 1.
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A);
    chk("sb_mem_wstrb", mem_wstrb, 4'b0010);
    chk("sb_mem_wdata", mem_wdata, 32'h00005A00);
    step();
    chk("sb_rsp_valid", rsp_valid, 1);
    step();

    // Word load at 0x006 crossing the 4-byte boundary.
`ifdef MEM_ACCESS_SPLIT_EN
    mem_rdata = 32'h11223344;
    issue(1'b0, 2'b10, 1'b0, 32'h006, 32'h0);
    chk("split_b1_addr", mem_addr, 32'h004);
    step();
    mem_rdata = 32'h55667788;
    chk("split_b2_valid", mem_valid, 1);
    chk("split_b2_addr", mem_addr, 32'h008);
    step();
    chk("split_rsp_valid", rsp_valid, 1);
    chk("split_rsp_err", rsp_err, 0);
    chk("split_rsp_rdata", rsp_rdata, 32'h77881122);
    step();
`else
    issue(1'b0, 2'b10, 1'b0, 32'h006, 32'h0);
    chk("misal_mem_valid", mem_valid, 0);
    chk("misal_rsp_valid", rsp_valid, 1);
    chk("misal_rsp_err", rsp_err, 1);
    chk("misal_rsp_rdata", rsp_rdata, 0);
    step();
    chk("misal_rsp_done", rsp_valid, 0);
`endif

    // Double-word size is illegal on a 32-bit bus.
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    chk("dbl_mem_valid", mem_valid, 0);
    chk("dbl_rsp_valid", rsp_valid, 1);
    chk("dbl_rsp_err", rsp_err, 1);
    step();

    // Timeout: mem_ready never comes, mem_valid held for exactly 4 cycles.
    mem_ready = 1'b0; mem_rdata = 32'hDEADBEEF;
    issue(1'b0, 2'b10, 1'b0, 32'h040, 32'h0);
    chk("to_wait1_valid", mem_valid, 1);
    step(); step(); step();
    chk("to_wait4_valid", mem_valid, 1);
    chk("to_wait4_no_rsp", rsp_valid, 0);
    step();
    chk("to_mem_dropped", mem_valid, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    step();

    // Reset in the middle of a beat abandons the transaction.
    issue(1'b0, 2'b10, 1'b0, 32'h080, 32'h0);
    chk("mid_beat_valid", mem_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_mem_valid", mem_valid, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rel_ready_before_edge", req_ready, 0);
    @(posedge clk);
    #1 chk("rel_ready_after_edge", req_ready, 1);
    chk("rel_no_rsp", rsp_valid, 0);
    @(negedge clk);

    // Normal service resumes after the abandoned transaction.
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    issue(1'b0, 2'b10, 1'b0, 32'h080, 32'h0);
    step();
    chk("post_rst_rdata", rsp_rdata, 32'hCAFEF00D);
    chk("post_rst_err", rsp_err, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
